// File: rtl/mul_div_unit_pkg.sv
// Shared MDop encodings for the EX-stage multiply/divide unit.
// Imported by the unit, its interface users and the bench.
package mul_div_unit_pkg;

  localparam logic [2:0] MDop_MULT  = 3'd0;
  localparam logic [2:0] MDop_MULTU = 3'd1;
  localparam logic [2:0] MDop_DIV   = 3'd2;
  localparam logic [2:0] MDop_DIVU  = 3'd3;
  localparam logic [2:0] MDop_MTHI  = 3'd4;
  localparam logic [2:0] MDop_MTLO  = 3'd5;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDop_MULT) || (op == MDop_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between EX control and the mul/div unit.
// master: start, MDop, cancel, busA, busB -> ; slave: busy, done, HI, LO ->
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       MDop;
  logic             cancel;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, MDop, cancel, busA, busB,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, MDop, cancel, busA, busB,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement: abs() on operands, sign fix on results.
// Ports: val in, neg in, res out (res = neg ? -val : val).
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? ('0 - val) : val;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO.
// Ports: clk, rst (async high), md (slave side of mul_div_unit_if).
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  md
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int W  = WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc;
  logic [W-1:0]  opb;
  logic          is_mul;
  logic          neg_q;
  logic          neg_r;
  logic          dz;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;

  logic          sa;
  logic          sb;
  logic [W-1:0]  abs_a;
  logic [W-1:0]  abs_b;
  logic          op_mul;
  logic          op_div;
  logic          op_mthi;
  logic          op_mtlo;

  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    unique case (1'b1)
      (md.MDop == MDop_MULT),
      (md.MDop == MDop_MULTU): op_mul  = 1'b1;
      (md.MDop == MDop_DIV),
      (md.MDop == MDop_DIVU):  op_div  = 1'b1;
      (md.MDop == MDop_MTHI):  op_mthi = 1'b1;
      (md.MDop == MDop_MTLO):  op_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign sa = is_signed_op(md.MDop) & md.busA[W-1];
  assign sb = is_signed_op(md.MDop) & md.busB[W-1];

  md_sign_fix #(.W(W)) u_abs_a (.val(md.busA), .neg(sa), .res(abs_a));
  md_sign_fix #(.W(W)) u_abs_b (.val(md.busB), .neg(sb), .res(abs_b));

  // Shared adder. Multiply: hi + (lsb ? mcand : 0).
  // Divide: partial remainder - divisor, carry-out = no borrow.
  logic [W-1:0] add_x;
  logic [W-1:0] add_y;
  logic [W:0]   sum;
  logic         q_ok;
  logic [2*W-1:0] step;

  always_comb begin
    add_x = is_mul ? acc[2*W-1:W] : acc[2*W-2:W-1];
    add_y = is_mul ? (acc[0] ? opb : '0) : ~opb;
    sum   = {1'b0, add_x} + {1'b0, add_y}
          + {{W{1'b0}}, ~is_mul};
    // Shifted-out top bit means the W+1-bit remainder already exceeds divisor.
    q_ok  = acc[2*W-1] | sum[W];
    if (is_mul)
      step = {sum, acc[W-1:1]};
    else
      step = {q_ok ? sum[W-1:0] : acc[2*W-2:W-1],
              acc[W-2:0], q_ok};
  end

  logic [2*W-1:0] res_in;
  logic [2*W-1:0] res_q;
  logic [W-1:0]   res_r;

  assign res_in = is_mul ? acc : {{W{1'b0}}, acc[W-1:0]};

  md_sign_fix #(.W(2*W)) u_fix_q (.val(res_in), .neg(neg_q), .res(res_q));
  md_sign_fix #(.W(W)) u_fix_r (.val(acc[2*W-1:W]), .neg(neg_r), .res(res_r));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (md.start && !md.cancel) begin
            if (op_mthi) hi_q <= md.busA;
            if (op_mtlo) lo_q <= md.busA;
            if (op_mul || op_div) begin
              is_mul <= op_mul;
              acc    <= {{W{1'b0}}, op_mul ? abs_b : abs_a};
              opb    <= op_mul ? abs_a : abs_b;
              neg_q  <= sa ^ sb;
              neg_r  <= op_div & sa;
              dz     <= op_div & (md.busB == '0);
              cnt    <= CW'(W);
              busy_q <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (md.cancel) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            acc <= step;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          state  <= IDLE;
          if (!md.cancel) begin
            done_q <= 1'b1;
            if (is_mul) begin
              hi_q <= res_q[2*W-1:W];
              lo_q <= res_q[W-1:0];
            end else begin
              // Remainder path already returns busA when dividing by zero.
              hi_q <= res_r;
              lo_q <= dz ? '1 : res_q[W-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized bench for mul_div_unit against an arithmetic HI/LO model.
// Covers directed corners, handshake, cancel and async reset.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk;
  logic rst;
  int checks;
  int errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mul_div_unit_if #(.WIDTH(32)) mif ();

  mul_div_unit #(.WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .md  (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MDop_MULT: begin
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      MDop_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      MDop_DIV: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      MDop_DIVU: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      MDop_MTHI: m_hi = a;
      MDop_MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  task automatic do_md(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input bit poke);
    int n;
    int dn;
    @(negedge clk);
    mif.start = 1'b1;
    mif.MDop  = op;
    mif.busA  = a;
    mif.busB  = b;
    @(negedge clk);
    mif.start = 1'b0;
    model(op, a, b);
    n  = 0;
    dn = 0;
    while (mif.busy === 1'b1 && n < 100) begin
      n++;
      if (mif.done === 1'b1) dn++;
      if (poke && n == 5) begin
        mif.start = 1'b1;
        mif.MDop  = MDop_MULTU;
        mif.busA  = $urandom;
        mif.busB  = $urandom;
      end else begin
        mif.start = 1'b0;
      end
      @(negedge clk);
    end
    mif.start = 1'b0;
    chk("busy_len", 32'(n), 32'd33);
    chk("done_early", 32'(dn), 32'd0);
    chk("done", 32'(mif.done), 32'd1);
    chk("hi", mif.HI, m_hi);
    chk("lo", mif.LO, m_lo);
    @(negedge clk);
    chk("done_pulse", 32'(mif.done), 32'd0);
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    mif.start = 1'b1;
    mif.MDop  = op;
    mif.busA  = a;
    mif.busB  = $urandom;
    @(negedge clk);
    mif.start = 1'b0;
    model(op, a, 32'd0);
    chk("mt_busy", 32'(mif.busy), 32'd0);
    chk("mt_done", 32'(mif.done), 32'd0);
    chk("mt_hi", mif.HI, m_hi);
    chk("mt_lo", mif.LO, m_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    logic [2:0] op;
    checks = 0;
    errors = 0;
    m_hi = '0;
    m_lo = '0;
    rst = 1'b1;
    mif.start  = 1'b0;
    mif.MDop   = '0;
    mif.cancel = 1'b0;
    mif.busA   = '0;
    mif.busB   = '0;
    #3;
    chk("rst_hi", mif.HI, 32'd0);
    chk("rst_lo", mif.LO, 32'd0);
    chk("rst_busy", 32'(mif.busy), 32'd0);
    chk("rst_done", 32'(mif.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_md(MDop_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_hi_k", mif.HI, 32'hFFFF_FFFE);
    do_md(MDop_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    chk("mult_lo_k", mif.LO, 32'hFFFF_FFF1);
    do_md(MDop_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo_k", mif.LO, 32'hFFFF_FFFD);
    do_md(MDop_DIVU, 32'd7, 32'd2, 1'b0);
    chk("divu_hi_k", mif.HI, 32'd1);
    do_md(MDop_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lo_k", mif.LO, 32'h8000_0000);
    do_md(MDop_DIVU, 32'h0000_1234, 32'd0, 1'b0);
    chk("divz_hi_k", mif.HI, 32'h0000_1234);
    do_md(MDop_DIV, 32'h8000_0000, 32'd0, 1'b0);
    do_mt(MDop_MTHI, 32'hA5A5_A5A5);
    do_mt(MDop_MTLO, 32'h5A5A_0F0F);
    do_md(MDop_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b1);

    // Flush a divide 10 cycles in; HI/LO must hold.
    @(negedge clk);
    mif.start = 1'b1;
    mif.MDop  = MDop_DIV;
    mif.busA  = 32'h7654_3210;
    mif.busB  = 32'd3;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (9) @(negedge clk);
    mif.cancel = 1'b1;
    @(negedge clk);
    mif.cancel = 1'b0;
    chk("cancel_busy", 32'(mif.busy), 32'd0);
    chk("cancel_done", 32'(mif.done), 32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (mif.done === 1'b1) dn++;
    end
    chk("cancel_nodone", 32'(dn), 32'd0);
    chk("cancel_hi", mif.HI, m_hi);
    chk("cancel_lo", mif.LO, m_lo);

    // Cancel with start in IDLE drops the request.
    mif.start  = 1'b1;
    mif.cancel = 1'b1;
    mif.MDop   = MDop_MTHI;
    mif.busA   = 32'hDEAD_BEEF;
    @(negedge clk);
    mif.start  = 1'b0;
    mif.cancel = 1'b0;
    chk("cstart_hi", mif.HI, m_hi);
    chk("cstart_busy", 32'(mif.busy), 32'd0);

    // Undefined code has no effect.
    mif.start = 1'b1;
    mif.MDop  = 3'd7;
    mif.busA  = 32'h1111_2222;
    mif.busB  = 32'h3;
    @(negedge clk);
    mif.start = 1'b0;
    chk("undef_busy", 32'(mif.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("undef_hi", mif.HI, m_hi);
    chk("undef_lo", mif.LO, m_lo);

    repeat (30) begin
      op = 3'($urandom_range(0, 5));
      if (op >= MDop_MTHI) do_mt(op, pick());
      else do_md(op, pick(), pick(), 1'b0);
    end

    // Async reset in the middle of a multiply.
    do_md(MDop_MULTU, 32'h0001_0003, 32'h0002_0005, 1'b0);
    @(negedge clk);
    mif.start = 1'b1;
    mif.MDop  = MDop_MULTU;
    mif.busA  = 32'h1234_5678;
    mif.busB  = 32'h9ABC_DEF0;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_hi", mif.HI, 32'd0);
    chk("arst_lo", mif.LO, 32'd0);
    chk("arst_busy", 32'(mif.busy), 32'd0);
    chk("arst_done", 32'(mif.done), 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    do_md(MDop_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the 5-stage MIPS datapath, sitting beside the combinational ALU in EX. Executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles and holds results in HI/LO. Also performs MTHI/MTLO writes. Exposes `busy` so the hazard unit can stall dependent MFHI/MFLO and later MD ops.

## Interface
- `WIDTH`, default 32: operand width; also HI/LO width and iteration count.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `MDop`  in  3  operation, sampled with `start`.
- `cancel`  in  1  pipeline flush; aborts an in-flight op.
- `busA`  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- `busB`  in  WIDTH  rt operand (divisor / multiplier).
- `busy`  out  1  registered; high while an op iterates.
- `done`  out  1  registered; one-cycle pulse when HI/LO receive a result.
- `HI`, `LO`  out  WIDTH  architectural HI/LO registers, continuously readable (MFHI/MFLO).

## Operation
- FSM states: IDLE, CALC, FIX.
- **Reset** (async, any time incl. mid-op):
  - State goes to IDLE.
  - `HI`=`LO`=0, `busy`=0, `done`=0.
  - Counter and working registers are cleared.
- **IDLE**:
  - MTHI/MTLO with `start`=1: the edge writes `busA` into HI or LO. No busy, no done.
  - MULT/MULTU/DIV/DIVU with `start`=1:
    - Latch operands (absolute values for signed ops), result signs, and div-by-zero flag.
    - Counter = WIDTH. Go to CALC. `busy`←1.
- **CALC**: one radix-2 step per edge; counter decrements. After the step that takes the counter to 0, go to FIX.
  - Multiply: shift-add, producing a 2·WIDTH unsigned product.
  - Divide: restoring division, producing unsigned quotient and remainder.
- **FIX** (one edge):
  - Apply sign correction.
  - Write HI/LO, `done`←1, `busy`←0, go to IDLE.
- **Arithmetic rules**:
  - Product is 2·WIDTH bits: HI = upper half, LO = lower half.
  - Product is negated when the operand signs differ (signed ops only).
  - LO = quotient, HI = remainder.
  - Signed quotient is negative iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Divide by zero (DIV or DIVU), same latency: LO = all ones, HI = `busA`.
  - DIV most-negative / −1: LO = most-negative, HI = 0. This falls out of the unsigned-magnitude datapath and needs no special case.
- **Boundaries**:
  - `start` while `busy`=1 is ignored. The hazard unit guarantees stalls.
  - `cancel` in CALC or FIX goes to IDLE on that edge:
    - `busy`←0, no `done`, HI/LO unchanged.
    - `cancel` beats a simultaneous FIX write.
  - `cancel` with `start` in IDLE: start is ignored.
  - Undefined MDop codes: no effect.

## Timing
- Accept edge E0.
  - `busy`=1 after E0.
  - Iterations run on E1..E_WIDTH.
  - FIX runs on E_(WIDTH+1).
  - HI/LO are valid and `done`=1 after E_(WIDTH+1); `busy`=0 from then.
- Latency: WIDTH+1 cycles from acceptance to result (33 for WIDTH=32).
- Back-to-back: a new `start` may be accepted on the edge after `done` rises. The cycle with `done`=1 has `busy`=0.
- MTHI/MTLO: result visible one cycle after the accept edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared header `Ctrl_encoding_def.v` gains the MDop constants:
  - `MDop_MULT`=0, `MDop_MULTU`=1, `MDop_DIV`=2, `MDop_DIVU`=3, `MDop_MTHI`=4, `MDop_MTLO`=5.
- FSM state encodings are local to the module.
- One natural sub-module: `md_sign_fix`. It is combinational and applies the conditional two's-complement used both on input (abs) and in FIX. It is instantiated for the operand path and the result path.
- Multiply and divide share one 2·WIDTH shift register and a WIDTH-bit adder/subtractor.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
  - `busy` high for exactly 33 cycles.
  - `done` pulses once, 33 cycles after the accept edge.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 2 → LO=3, HI=1.
- Corner divides:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234.
- Handshake:
  - MTHI 0xA5A5A5A5 when idle → HI=0xA5A5A5A5 next cycle, `busy` stays 0.
  - A second `start` during busy leaves the first result intact.
- `cancel` 10 cycles into DIV → `busy`=0 next cycle, no `done`, HI/LO keep prior values.
- `rst` asserted mid-MULT → HI=LO=0, `busy`=`done`=0 immediately, without waiting for a clock edge.
